alu_arbiter: RTL and testbench

- Shares one combinational 8-bit ALU (3-bit opcode) between two requesters.
- Each requester uses a valid/ready handshake. A round-robin grant picks the winner.
- The arbiter latches the winner's operands and drives the ALU from registered ports. It captures the result and returns it on a single response channel with requester ID and zero flag.
- Sits between the two operation sources and the ALU instance; the ALU is external and wired to the alu_* ports.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin arbiter sharing one external ALU between two
//               valid/ready requesters, with a single response channel.
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_last_grant;
    logic   r_id;
    logic   w_grant;
    logic   w_accept;

    always_comb begin
        w_grant = req1_valid;
        // Under contention the requester that did not win last time goes first.
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end
        w_accept = (r_state == S_IDLE) && (req0_valid || req1_valid);
    end

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept && w_grant;
    assign busy       = (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_RESP;
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_id       <= 1'b0;
            rsp_zero     <= 1'b0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_a        <= w_grant ? req1_a  : req0_a;
                        alu_b        <= w_grant ? req1_b  : req0_b;
                        alu_op       <= w_grant ? req1_op : req0_op;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_zero  <= (alu_out == '0);
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed self-checking bench for alu_arbiter with a small
//                  behavioural ALU attached to the alu_* ports.
// Revision       : 1.0
// ============================================================================
module tb_alu_arbiter;
    localparam int WIDTH = 8;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [OPW-1:0]   alu_op;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [WIDTH-1:0] rsp_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 SUB, 101 ADD, 110 MUL, 111 zero
    always_comb begin
        case (alu_op)
            3'b000:  alu_out = ~alu_a;
            3'b001:  alu_out = alu_a & alu_b;
            3'b010:  alu_out = alu_a | alu_b;
            3'b011:  alu_out = alu_a ^ alu_b;
            3'b100:  alu_out = alu_a - alu_b;
            3'b101:  alu_out = alu_a + alu_b;
            3'b110:  alu_out = alu_a * alu_b;
            default: alu_out = '0;
        endcase
    end

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_zero(rsp_zero), .busy(busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one op from requester id and returns the response fields (rsp_ready must be 1).
    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, output logic [7:0] d, output logic rid,
                          output logic z, output logic timeout);
        int n;
        timeout = 1'b0;
        @(negedge clk);
        if (!id) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 8) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 8) timeout = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 8) timeout = 1'b1;
        d = rsp_data; rid = rsp_id; z = rsp_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if ({rsp_valid, busy, rsp_id, rsp_zero, req0_ready, req1_ready} !== 6'b0) begin
            $display("FAIL reset_flags: got %b want 000000",
                     {rsp_valid, busy, rsp_id, rsp_zero, req0_ready, req1_ready});
        end else pass_cnt++;
        total_cnt++;
        if ({alu_a, alu_b, alu_op, rsp_data} !== 27'h0) begin
            $display("FAIL reset_regs: got a=%h b=%h op=%b data=%h want all zero",
                     alu_a, alu_b, alu_op, rsp_data);
        end else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        rsp_ready = 1'b0;
        @(negedge clk);
        req0_a = 8'h7F; req0_b = 8'h01; req0_op = 3'b101; req0_valid = 1'b1;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end else pass_cnt++;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        total_cnt++;
        if ({busy, rsp_valid, req0_ready} !== 3'b100) begin
            $display("FAIL single_exec: busy/rsp_valid/ready got %b want 100",
                     {busy, rsp_valid, req0_ready});
        end else pass_cnt++;
        total_cnt++;
        if ({alu_a, alu_b, alu_op} !== {8'h7F, 8'h01, 3'b101}) begin
            $display("FAIL single_alu_regs: got %h %h %b want 7f 01 101", alu_a, alu_b, alu_op);
        end else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_zero} !== {1'b1, 8'h80, 1'b0, 1'b0}) begin
            $display("FAIL single_rsp: got v=%b d=%h id=%b z=%b want v=1 d=80 id=0 z=0",
                     rsp_valid, rsp_data, rsp_id, rsp_zero);
        end else pass_cnt++;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({rsp_valid, busy} !== 2'b00) begin
            $display("FAIL single_done: rsp_valid/busy got %b want 00", {rsp_valid, busy});
        end else pass_cnt++;
        total_cnt++;
        if ({alu_a, alu_b, alu_op} !== {8'h7F, 8'h01, 3'b101}) begin
            $display("FAIL single_alu_hold: got %h %h %b want 7f 01 101", alu_a, alu_b, alu_op);
        end else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic       exp_id;
        logic [7:0] exp_d;
        int         n;
        pulse_reset();
        rsp_ready  = 1'b1;
        req0_a = 8'h05; req0_b = 8'h07; req0_op = 3'b100; req0_valid = 1'b1;
        req1_a = 8'hAA; req1_b = 8'h55; req1_op = 3'b011; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            exp_d  = exp_id ? 8'hFF : 8'hFE;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 8) begin
                @(negedge clk); #1; n++;
            end
            total_cnt++;
            if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) begin
                $display("FAIL fair_grant%0d: req1/req0 ready got %b want %b",
                         i, {req1_ready, req0_ready}, {exp_id, ~exp_id});
            end else pass_cnt++;
            @(negedge clk); #1;
            n = 0;
            while (!rsp_valid && n < 8) begin
                @(negedge clk); #1; n++;
            end
            total_cnt++;
            if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, exp_d, exp_id}) begin
                $display("FAIL fair_rsp%0d: got v=%b d=%h id=%b want v=1 d=%h id=%b",
                         i, rsp_valid, rsp_data, rsp_id, exp_d, exp_id);
            end else pass_cnt++;
            @(negedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_a = 8'h10; req0_b = 8'h10; req0_op = 3'b110; req0_valid = 1'b1;
        #1;
        total_cnt++;
        if (req0_ready !== 1'b1) begin
            $display("FAIL bp_accept: req0_ready got %b want 1", req0_ready);
        end else pass_cnt++;
        @(negedge clk);
        req1_a = 8'h0F; req1_b = 8'hF0; req1_op = 3'b011; req1_valid = 1'b1;
        @(negedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if ({rsp_valid, rsp_data, rsp_zero, req0_ready, req1_ready} !==
                {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL bp_hold%0d: got v=%b d=%h z=%b rdy=%b%b want v=1 d=00 z=1 rdy=00",
                         k, rsp_valid, rsp_data, rsp_zero, req0_ready, req1_ready);
            end else pass_cnt++;
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            $display("FAIL bp_ready_same_cycle: got %b want 00", {req0_ready, req1_ready});
        end else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
            $display("FAIL bp_release: v/rdy0/rdy1 got %b want 001",
                     {rsp_valid, req0_ready, req1_ready});
        end else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_opcodes();
        logic [7:0] d;
        logic       rid, z, to;
        rsp_ready = 1'b1;
        run_op(1'b0, 8'hFF, 8'hFF, 3'b111, d, rid, z, to);
        total_cnt++;
        if ({to, d, rid, z} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            $display("FAIL op111: got to=%b d=%h id=%b z=%b want to=0 d=00 id=0 z=1", to, d, rid, z);
        end else pass_cnt++;
        run_op(1'b1, 8'h0F, 8'h00, 3'b000, d, rid, z, to);
        total_cnt++;
        if ({to, d, rid, z} !== {1'b0, 8'hF0, 1'b1, 1'b0}) begin
            $display("FAIL op000: got to=%b d=%h id=%b z=%b want to=0 d=f0 id=1 z=0", to, d, rid, z);
        end else pass_cnt++;
        run_op(1'b0, 8'h3C, 8'h0F, 3'b001, d, rid, z, to);
        total_cnt++;
        if ({to, d, rid, z} !== {1'b0, 8'h0C, 1'b0, 1'b0}) begin
            $display("FAIL op001: got to=%b d=%h id=%b z=%b want to=0 d=0c id=0 z=0", to, d, rid, z);
        end else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int vcnt;
        rsp_ready = 1'b0;
        req0_a = 8'h01; req0_b = 8'h01; req0_op = 3'b101; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        total_cnt++;
        if ({busy, rsp_valid} !== 2'b10) begin
            $display("FAIL mid_exec_pre: busy/rsp_valid got %b want 10", {busy, rsp_valid});
        end else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({rsp_valid, busy, alu_a, alu_op} !== 13'h0) begin
            $display("FAIL mid_exec_reset: v=%b busy=%b a=%h op=%b want all zero",
                     rsp_valid, busy, alu_a, alu_op);
        end else pass_cnt++;
        req1_valid = 1'b1;
        req0_valid = 1'b1;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL mid_exec_grant: got %b want 10", {req0_ready, req1_ready});
        end else pass_cnt++;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk); #1;
        total_cnt++;
        if ({rsp_valid, rsp_data} !== {1'b1, 8'h02}) begin
            $display("FAIL mid_resp_pre: got v=%b d=%h want v=1 d=02", rsp_valid, rsp_data);
        end else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({rsp_valid, busy, rsp_data, rsp_id, rsp_zero} !== 12'h0) begin
            $display("FAIL mid_resp_reset: v=%b busy=%b d=%h id=%b z=%b want all zero",
                     rsp_valid, busy, rsp_data, rsp_id, rsp_zero);
        end else pass_cnt++;
        rsp_ready = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (rsp_valid) vcnt++;
        end
        total_cnt++;
        if (vcnt !== 0) begin
            $display("FAIL mid_no_rsp: responses seen %0d want 0", vcnt);
        end else pass_cnt++;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL mid_resp_grant: got %b want 10", {req0_ready, req1_ready});
        end else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_withdraw();
        int         vcnt;
        logic [7:0] d;
        logic       rid, seen_r1;
        pulse_reset();
        rsp_ready = 1'b1;
        req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'b101; req0_valid = 1'b1;
        req1_a = 8'h0F; req1_b = 8'hF0; req1_op = 3'b011; req1_valid = 1'b1;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL wd_grant: got %b want 10", {req0_ready, req1_ready});
        end else pass_cnt++;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vcnt = 0; d = '0; rid = 1'b1; seen_r1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin
                vcnt++; d = rsp_data; rid = rsp_id;
            end
            if (req1_ready) seen_r1 = 1'b1;
        end
        total_cnt++;
        if (vcnt !== 1 || {d, rid, seen_r1} !== {8'h03, 1'b0, 1'b0}) begin
            $display("FAIL wd_rsp: count=%0d d=%h id=%b r1rdy=%b want count=1 d=03 id=0 r1rdy=0",
                     vcnt, d, rid, seen_r1);
        end else pass_cnt++;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total_cnt++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("FAIL wd_last_grant: got %b want 01", {req0_ready, req1_ready});
        end else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_opcodes();
        test_reset_mid();
        test_withdraw();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
